systolic_matmul_engine: RTL and testbench
=========================================

SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4: PE rows, and the activation vector length (2..16).
REQ-002 SHALL have parameter COLS, default 4: PE columns, and the result vector length (2..16).
REQ-003 SHALL have parameter DATA_SIZE, default 16: signed weight/activation width.
REQ-004 SHALL have parameter ACC_SIZE, default 32: signed accumulator/result width, with ACC_SIZE >= 2*DATA_SIZE.
REQ-005 SHALL have parameter CNT_SIZE, default 16: width of the vector-count field.
REQ-006 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, width 1: synchronous, active-high.
REQ-008 SHALL have port start, input, width 1: command pulse.
REQ-009 SHALL have port num_vectors, input, width CNT_SIZE: activation vectors in the job; sampled with start.
REQ-010 SHALL have port weights_input, input, COLS x DATA_SIZE: one weight row.
REQ-011 SHALL have port w_valid, input, width 1: weights_input valid. w_ready, output, width 1: weight row accepted this cycle when w_valid=1.
REQ-012 SHALL have port data_input, input, ROWS x DATA_SIZE: one activation vector.
REQ-013 SHALL have port in_valid, input, width 1: data_input valid. in_ready, output, width 1: vector accepted this cycle when in_valid=1.
REQ-014 SHALL have port result_out, output, COLS x ACC_SIZE: result vector. out_valid, output, width 1: result_out valid (no backpressure).
REQ-015 SHALL have port busy, output, width 1: a job is in progress. done, output, width 1: one-cycle job-complete pulse.

Function
REQ-016 SHALL be weight-stationary: for each accepted x, result_out[c] = sum over r of x[r]*W[r][c], products signed.
REQ-017 SHALL run an FSM with states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-018 IDLE: start=1 -> LOAD_W; latch num_vectors; busy=1 from the next cycle.
REQ-019 LOAD_W: w_ready=1; each w_valid cycle loads row index 0,1,..ROWS-1 in order; after row ROWS-1 -> STREAM, or -> DONE if latched num_vectors=0.
REQ-020 STREAM: in_ready=1 until num_vectors vectors are accepted; in_valid=0 cycles insert bubbles; after the last accept -> DRAIN.
REQ-021 DRAIN: hold for L=ROWS+COLS cycles, then -> DONE. DONE: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
REQ-022 Latency: vector accepted at cycle t gives out_valid=1 at t+L with all COLS results aligned (internal input skew/output deskew); results in acceptance order; bubbles yield out_valid=0.
REQ-023 The array SHALL advance every cycle; throughput is one vector per cycle.
REQ-024 start while busy=1 SHALL be ignored; w_valid outside LOAD_W and in_valid outside STREAM are ignored.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_SIZE unless SA_SATURATE_EN is defined.
REQ-026 Weights SHALL persist after DONE until the next LOAD_W overwrites them.

Reset
REQ-027 reset=1 SHALL force IDLE and clear weights, pipeline, valid bits and counters in the same edge, including mid-job.
REQ-028 While reset=1 and on the first cycle after it: busy, done, w_ready, in_ready and out_valid are 0, and result_out is all 0.

Configuration
REQ-029 SA_SATURATE_EN defined: every PE add saturates to the signed ACC_SIZE range [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1]. Undefined: two's-complement wrap; all other behaviour identical.

Verification (ROWS=COLS=2, DATA_SIZE=16, ACC_SIZE=32, L=4)
REQ-030 Bench: start, num_vectors=1; W rows [1,2],[3,4]; x=[5,6] accepted at t -> out_valid at t+4, result_out=[23,34]; done follows the drain.
REQ-031 Bench: 3 back-to-back vectors [1,0],[0,1],[-1,-1] -> consecutive outputs [1,2],[3,4],[-4,-6].
REQ-032 Bench: bubble, in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 starting at t+4.
REQ-033 Bench: num_vectors=0 -> LOAD_W completes, then done pulses with no out_valid; a start issued mid-job is ignored.
REQ-034 Bench: reset asserted during STREAM -> next cycle busy=0, out_valid=0, result_out=0; a new job then runs correctly with W=0 until weights are reloaded.
REQ-035 Bench: ACC_SIZE=32, W all 32767, x all -32768 -> wrap result without the macro; with SA_SATURATE_EN the result equals the exact sum -2147418112 (no clamp needed).

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: weight-stationary ROWSxCOLS systolic matrix-vector engine.
// Define SA_SATURATE_EN to make every PE accumulation saturate instead of wrapping.
module systolic_matmul_engine #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DATA_SIZE = 16,
  parameter int ACC_SIZE  = 32,
  parameter int CNT_SIZE  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_SIZE-1:0]            num_vectors,
  input  logic [COLS-1:0][DATA_SIZE-1:0] weights_input,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [ROWS-1:0][DATA_SIZE-1:0] data_input,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [COLS-1:0][ACC_SIZE-1:0]  result_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           done
);
  localparam int L  = ROWS + COLS;
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(L);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  typedef logic signed [DATA_SIZE-1:0] data_t;
  typedef logic signed [ACC_SIZE-1:0] acc_t;
  state_t state_q, state_d;
  logic [CNT_SIZE-1:0] num_q, num_d, vec_q, vec_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] drn_q, drn_d;
  logic accept;
  data_t w_q [ROWS][COLS], w_d [ROWS][COLS];
  data_t a_q [ROWS][COLS], a_d [ROWS][COLS];
  acc_t p_q [ROWS][COLS], p_d [ROWS][COLS], pin [ROWS][COLS];
  data_t skew_q [ROWS][ROWS-1], skew_d [ROWS][ROWS-1], sk [ROWS][ROWS];
  acc_t dsk_q [COLS][COLS-1], dsk_d [COLS][COLS-1], ds [COLS][COLS];
  logic [L-1:0] vld_q, vld_d;
  logic [COLS-1:0][ACC_SIZE-1:0] res_q, res_d;

  function automatic acc_t mac(acc_t p, data_t a, data_t w);
    logic signed [2*DATA_SIZE-1:0] pr;
    acc_t e;
`ifdef SA_SATURATE_EN
    logic [ACC_SIZE:0] s;
`endif
    pr = a * w;
    e = ACC_SIZE'(pr);
`ifdef SA_SATURATE_EN
    s = {p[ACC_SIZE-1], p} + {e[ACC_SIZE-1], e};
    return (s[ACC_SIZE] != s[ACC_SIZE-1]) ? {s[ACC_SIZE], {(ACC_SIZE-1){~s[ACC_SIZE]}}} : s[ACC_SIZE-1:0];
`else
    return p + e;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    num_d = num_q;
    vec_d = vec_q;
    row_d = row_q;
    drn_d = drn_q;
    w_d = w_q;
    accept = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_W;
        num_d = num_vectors;
        row_d = '0;
      end
      LOAD_W: if (w_valid) begin
        for (int c = 0; c < COLS; c++) w_d[row_q][c] = weights_input[c];
        row_d = row_q + 1'b1;
        vec_d = '0;
        if (row_q == RW'(ROWS-1)) state_d = (num_q == '0) ? DONE : STREAM;
      end
      STREAM: if (in_valid) begin
        accept = 1'b1;
        vec_d = vec_q + 1'b1;
        drn_d = '0;
        if (vec_q == num_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DW'(L-1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row r sees its activation r cycles late; column c result is then delayed COLS-1-c to realign.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      sk[r][0] = accept ? data_input[r] : '0;
      for (int k = 1; k < ROWS; k++) sk[r][k] = skew_q[r][k-1];
      for (int k = 0; k < ROWS-1; k++) skew_d[r][k] = sk[r][k];
      a_d[r][0] = sk[r][r];
      for (int c = 1; c < COLS; c++) a_d[r][c] = a_q[r][c-1];
    end
    for (int c = 0; c < COLS; c++) pin[0][c] = '0;
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pin[r][c] = p_q[r-1][c];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) p_d[r][c] = mac(pin[r][c], a_d[r][c], w_q[r][c]);
    for (int c = 0; c < COLS; c++) begin
      ds[c][0] = p_q[ROWS-1][c];
      for (int k = 1; k < COLS; k++) ds[c][k] = dsk_q[c][k-1];
      for (int k = 0; k < COLS-1; k++) dsk_d[c][k] = ds[c][k];
      res_d[c] = ds[c][COLS-1-c];
    end
    vld_d = {vld_q[L-2:0], accept};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q <= '0;
      vec_q <= '0;
      row_q <= '0;
      drn_q <= '0;
      w_q <= '{default: '0};
      a_q <= '{default: '0};
      p_q <= '{default: '0};
      skew_q <= '{default: '0};
      dsk_q <= '{default: '0};
      vld_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      vec_q <= vec_d;
      row_q <= row_d;
      drn_q <= drn_d;
      w_q <= w_d;
      a_q <= a_d;
      p_q <= p_d;
      skew_q <= skew_d;
      dsk_q <= dsk_d;
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign w_ready = state_q == LOAD_W;
  assign in_ready = state_q == STREAM;
  assign out_valid = vld_q[L-1];
  assign result_out = res_q;
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb_systolic_matmul_engine: randomized bench with an arithmetic reference model and output scoreboard.
module tb_systolic_matmul_engine;
  localparam int R = 2, C = 2, D = 16, A = 32, N = 16, L = R + C;
  typedef logic [R-1:0][D-1:0] vec_t;
  typedef logic [C-1:0][A-1:0] res_t;
  typedef struct {res_t res; int t;} exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, w_valid = 1'b0, in_valid = 1'b0;
  logic [N-1:0] num_vectors = '0;
  logic [C-1:0][D-1:0] weights_input = '0;
  vec_t data_input = '0;
  logic w_ready, in_ready, out_valid, busy, done;
  res_t result_out, last_res = '0;
  int checks = 0, errors = 0, cyc = 0, outs = 0, last_t = 0;
  int wm [R][C];
  exp_t q[$];
  vec_t xs[$];

  systolic_matmul_engine #(.ROWS(R), .COLS(C), .DATA_SIZE(D), .ACC_SIZE(A), .CNT_SIZE(N)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
    .weights_input(weights_input), .w_valid(w_valid), .w_ready(w_ready),
    .data_input(data_input), .in_valid(in_valid), .in_ready(in_ready),
    .result_out(result_out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(vec_t x);
    res_t y;
    longint acc;
    for (int c = 0; c < C; c++) begin
      acc = 0;
      for (int r = 0; r < R; r++) begin
        acc += longint'($signed(x[r])) * longint'(wm[r][c]);
`ifdef SA_SATURATE_EN
        if (acc > (64'sd1 <<< (A-1)) - 1) acc = (64'sd1 <<< (A-1)) - 1;
        if (acc < -(64'sd1 <<< (A-1))) acc = -(64'sd1 <<< (A-1));
`endif
      end
      y[c] = acc[A-1:0];
    end
    return y;
  endfunction

  function automatic vec_t mkx(int a, int b);
    vec_t v;
    v[0] = D'(a);
    v[1] = D'(b);
    return v;
  endfunction

  always @(negedge clk) if (out_valid) begin
    exp_t e;
    outs++;
    last_res = result_out;
    if (q.size() == 0) chk("spurious_out", 1, 0);
    else begin
      e = q.pop_front();
      chk("latency", 64'(cyc - e.t), 64'(L));
      chk("result", result_out, e.res);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; w_valid = 1'b0; in_valid = 1'b0;
    tick();
    q.delete();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wready", w_ready, 0);
    chk("rst_inready", in_ready, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_result", result_out, 0);
    reset = 1'b0;
  endtask

  task automatic start_job(int n);
    start = 1'b1;
    num_vectors = N'(n);
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  task automatic load_w(bit gaps);
    for (int r = 0; r < R; r++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        data_input = vec_t'($urandom);
        tick();
      end
      in_valid = 1'b0;
      for (int c = 0; c < C; c++) weights_input[c] = D'(wm[r][c]);
      w_valid = 1'b1;
      chk("w_ready", w_ready, 1);
      tick();
      w_valid = 1'b0;
    end
  endtask

  task automatic send(vec_t x);
    data_input = x;
    in_valid = 1'b1;
    w_valid = 1'($urandom_range(0, 1));
    weights_input = ($urandom);
    chk("in_ready", in_ready, 1);
    q.push_back('{model(x), cyc});
    last_t = cyc;
    tick();
    in_valid = 1'b0;
    w_valid = 1'b0;
  endtask

  task automatic wait_done(string tag, bit had_vec);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk(tag, seen, 1);
    if (seen) begin
      if (had_vec) chk("done_lat", 64'(cyc - last_t), 64'(L + 1));
      tick();
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
    end
    chk("drained", 64'(q.size()), 0);
  endtask

  task automatic rand_w();
    logic signed [D-1:0] v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        v = D'($urandom);
        wm[r][c] = int'(v);
      end
  endtask

  task automatic run_job(int bub);
    start_job(xs.size());
    load_w(1'b1);
    foreach (xs[i]) begin
      while ($urandom_range(0, 99) < bub) tick();
      send(xs[i]);
    end
    wait_done("job_done", xs.size() != 0);
  endtask

  initial begin
    int b;
    tick(2);
    do_reset();
    wm = '{'{1, 2}, '{3, 4}};
    xs = '{mkx(5, 6)};
    run_job(0);
    chk("basic", last_res, {32'd34, 32'd23});
    xs = '{mkx(1, 0), mkx(0, 1), mkx(-1, -1)};
    run_job(0);
    chk("b2b_last", last_res, {32'hFFFF_FFFA, 32'hFFFF_FFFC});
    start_job(2);
    load_w(1'b0);
    send(mkx(7, -3));
    start = 1'b1;
    num_vectors = N'(1);
    tick();
    start = 1'b0;
    chk("restart_ignored", in_ready, 1);
    send(mkx(-8, 9));
    wait_done("bubble_done", 1'b1);
    b = outs;
    start_job(0);
    start = 1'b1;
    num_vectors = N'(3);
    load_w(1'b1);
    start = 1'b0;
    wait_done("nv0_done", 1'b0);
    chk("nv0_no_out", 64'(outs - b), 0);
    rand_w();
    start_job(4);
    load_w(1'b0);
    send(vec_t'($urandom));
    send(vec_t'($urandom));
    reset = 1'b1;
    tick();
    q.delete();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outvalid", out_valid, 0);
    chk("mid_rst_result", result_out, 0);
    reset = 1'b0;
    b = outs;
    tick(L + 2);
    chk("mid_rst_quiet", 64'(outs - b), 0);
    wm = '{'{0, 0}, '{0, 0}};
    xs = '{mkx(1234, -4321), mkx(-32768, 32767)};
    run_job(20);
    chk("zero_w", last_res, 0);
    wm = '{'{32767, 32767}, '{32767, 32767}};
    xs = '{mkx(-32768, -32768)};
    run_job(0);
    chk("extreme", last_res, {32'h8001_0000, 32'h8001_0000});
    wm = '{'{-32768, -32768}, '{-32768, -32768}};
    xs = '{mkx(-32768, -32768)};
    run_job(0);
`ifdef SA_SATURATE_EN
    chk("overflow", last_res, {32'h7FFF_FFFF, 32'h7FFF_FFFF});
`else
    chk("overflow", last_res, {32'h8000_0000, 32'h8000_0000});
`endif
    for (int j = 0; j < 8; j++) begin
      rand_w();
      xs.delete();
      repeat ($urandom_range(1, 6)) xs.push_back(vec_t'($urandom));
      run_job(30);
    end
    tick(L + 2);
    chk("final_drained", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
